mod_exp_engine: RTL and testbench

Sequential modular-exponentiation engine that computes result = msg^exponent mod modulus on 16-bit operands. It sits directly downstream of the RSA decryption-key generator. It consumes the generated modulus n and either the public exponent e (encrypt) or the private exponent d (decrypt), and performs the actual RSA transform. It uses right-to-left square-and-multiply with two parallel bit-serial interleaved modular multipliers, so it needs no hardware multiplier or divider.

---
 rtl/mod_exp_if.sv | 23 ++
 rtl/mod_exp_engine.sv | 145 ++++++++++++++
 tb/tb_mod_exp_engine.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/mod_exp_if.sv
// Request/response bundle for the modular-exponentiation engine.
interface mod_exp_if;
  logic        start;
  logic [15:0] msg;
  logic [15:0] exponent;
  logic [15:0] modulus;
  logic [15:0] result;
  logic        busy;
  logic        done;
  logic        err;

  // Requester side: drives operands, observes status and result.
  modport master (
    output start, msg, exponent, modulus,
    input  result, busy, done, err
  );

  // Engine side: samples operands, drives status and result.
  modport slave (
    input  start, msg, exponent, modulus,
    output result, busy, done, err
  );
endinterface

// File: rtl/mod_exp_engine.sv
// 16-bit modular exponentiation, right-to-left square-and-multiply using two
// bit-serial interleaved modular multipliers (no multiplier/divider needed).
// Latency is data-independent: all 16 exponent bits are always processed.
module mod_exp_engine (
  input  logic       clk,
  input  logic       rst_n,
  mod_exp_if.slave   bus
);

  localparam int unsigned W  = 16;
  localparam int unsigned AW = 18;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_MUL,
    S_NEXT,
    S_DONE
  } state_e;

  state_e          state_q;
  logic [W-1:0]    msg_q;
  logic [W-1:0]    e_q;
  logic [W-1:0]    n_q;
  logic [W-1:0]    r_q;
  logic [W-1:0]    b_q;
  logic [AW-1:0]   acc1_q;
  logic [AW-1:0]   acc2_q;
  logic [3:0]      jcnt_q;
  logic [4:0]      bitcnt_q;
  logic [W-1:0]    result_q;
  logic            busy_q;
  logic            done_q;
  logic            err_q;

  logic [AW-1:0]   acc1_d;
  logic [AW-1:0]   acc2_d;
  logic [W-1:0]    r_d;

  // One interleaved step: acc = 2*acc + (abit ? b : 0), reduced below n.
  // With acc < n and b < n the sum is < 3n, so two subtractions suffice.
  function automatic logic [AW-1:0] mm_step(
    input logic [AW-1:0] acc,
    input logic          abit,
    input logic [W-1:0]  b,
    input logic [W-1:0]  n
  );
    logic [AW-1:0] t;
    t = {acc[AW-2:0], 1'b0} + (abit ? AW'(b) : AW'(0));
    if (t >= AW'(n)) t = t - AW'(n);
    if (t >= AW'(n)) t = t - AW'(n);
    return t;
  endfunction

  // Multiplier steps (P1 = R*B, P2 = B*B) and the post-bit value of R.
  always_comb begin
    acc1_d = mm_step(acc1_q, r_q[jcnt_q], b_q, n_q);
    acc2_d = mm_step(acc2_q, b_q[jcnt_q], b_q, n_q);
    r_d    = e_q[0] ? acc1_q[W-1:0] : r_q;
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      msg_q    <= '0;
      e_q      <= '0;
      n_q      <= '0;
      r_q      <= '0;
      b_q      <= '0;
      acc1_q   <= '0;
      acc2_q   <= '0;
      jcnt_q   <= '0;
      bitcnt_q <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          busy_q <= 1'b0;
          if (bus.start) begin
            msg_q   <= bus.msg;
            e_q     <= bus.exponent;
            n_q     <= bus.modulus;
            busy_q  <= 1'b1;
            state_q <= S_INIT;
          end
        end
        S_INIT: begin
          if ((n_q < W'(2)) || (msg_q >= n_q)) begin
            err_q    <= 1'b1;
            result_q <= '0;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end else begin
            r_q      <= W'(1);
            b_q      <= msg_q;
            bitcnt_q <= '0;
            err_q    <= 1'b0;
            acc1_q   <= '0;
            acc2_q   <= '0;
            jcnt_q   <= 4'(W - 1);
            state_q  <= S_MUL;
          end
        end
        S_MUL: begin
          acc1_q <= acc1_d;
          acc2_q <= acc2_d;
          jcnt_q <= jcnt_q - 4'd1;
          if (jcnt_q == 4'd0) state_q <= S_NEXT;
        end
        S_NEXT: begin
          r_q      <= r_d;
          b_q      <= acc2_q[W-1:0];
          e_q      <= e_q >> 1;
          bitcnt_q <= bitcnt_q + 5'd1;
          acc1_q   <= '0;
          acc2_q   <= '0;
          jcnt_q   <= 4'(W - 1);
          if (bitcnt_q == 5'(W - 1)) begin
            result_q <= r_d;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end else begin
            state_q  <= S_MUL;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.result = result_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.err    = err_q;

endmodule

// File: tb/tb_mod_exp_engine.sv
// Self-checking bench for mod_exp_engine: vector table, keygen round trip,
// random vectors and hand-written busy/reset/error sequences.
module tb_mod_exp_engine;

  logic clk;
  logic rst_n;
  mod_exp_if bus ();

  mod_exp_engine dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] m;
    logic [15:0] e;
    logic [15:0] n;
    logic [15:0] res;
    logic        err;
  } vec_t;

  typedef struct {
    logic [15:0] res;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_mis = 0;
  int   cur_cyc;
  int   busy_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Reference model: plain arithmetic modular exponentiation.
  function automatic exp_t model(input logic [15:0] m, input logic [15:0] e, input logic [15:0] n);
    exp_t x;
    longint unsigned r, b;
    x.lat = 274;
    if (n < 2 || m >= n) begin
      x.res = 16'd0; x.err = 1'b1; x.lat = 2;
      return x;
    end
    r = 1; b = longint'(m);
    for (int i = 0; i < 16; i++) begin
      if (e[i]) r = (r * b) % longint'(n);
      b = (b * b) % longint'(n);
    end
    x.res = 16'(r); x.err = 1'b0;
    return x;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
    cur_cyc++;
    if (bus.busy) busy_cnt++;
  endtask

  // Drive a start pulse; returns in cycle 1 (the INIT cycle).
  task automatic launch(input logic [15:0] m, input logic [15:0] e, input logic [15:0] n);
    @(negedge clk);
    bus.start = 1'b1; bus.msg = m; bus.exponent = e; bus.modulus = n;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.msg = 16'($urandom); bus.exponent = 16'($urandom); bus.modulus = 16'($urandom);
    cur_cyc = 1;
    busy_cnt = bus.busy ? 1 : 0;
  endtask

  // Wait for done, pop the scoreboard, compare result/err/latency/busy.
  task automatic finish_txn(input string tag, output logic [15:0] got);
    exp_t x;
    bit   seen;
    seen = 1'b0;
    got  = 16'd0;
    while (cur_cyc < 400) begin
      if (bus.done) begin seen = 1'b1; break; end
      tick();
    end
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
      return;
    end
    x = sb.pop_front();
    if (!seen) begin
      chk({tag, "_timeout"}, 32'(cur_cyc), 32'(x.lat));
      return;
    end
    got = bus.result;
    chk({tag, "_result"}, 32'(bus.result), 32'(x.res));
    chk({tag, "_err"}, 32'(bus.err), 32'(x.err));
    chk({tag, "_latency"}, 32'(cur_cyc), 32'(x.lat));
    chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(x.lat));
    tick();
    chk({tag, "_done_after"}, 32'(bus.done), 32'd0);
    chk({tag, "_busy_after"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic run_txn(input string tag, input logic [15:0] m, input logic [15:0] e,
                         input logic [15:0] n, input exp_t x, output logic [15:0] got);
    sb.push_back(x);
    launch(m, e, n);
    finish_txn(tag, got);
  endtask

  function automatic int mod_inv(input int e, input int phi);
    for (int d = 1; d < phi; d++)
      if ((e * d) % phi == 1) return d;
    return 0;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl [8];
    exp_t        x;
    logic [15:0] got, ct, m, n;
    int          d, pk, qk, dones;

    tbl[0] = '{16'd65,    16'd17,    16'd3233,  16'd2790, 1'b0};
    tbl[1] = '{16'd2790,  16'd2753,  16'd3233,  16'd65,   1'b0};
    tbl[2] = '{16'd65024, 16'd2,     16'd65025, 16'd1,    1'b0};
    tbl[3] = '{16'd0,     16'd0,     16'd3233,  16'd1,    1'b0};
    tbl[4] = '{16'd0,     16'd65535, 16'd3233,  16'd0,    1'b0};
    tbl[5] = '{16'd3233,  16'd17,    16'd3233,  16'd0,    1'b1};
    tbl[6] = '{16'd5,     16'd3,     16'd1,     16'd0,    1'b1};
    tbl[7] = '{16'd65,    16'd17,    16'd3233,  16'd2790, 1'b0};

    rst_n = 1'b0;
    bus.start = 1'b0; bus.msg = '0; bus.exponent = '0; bus.modulus = '0;
    #23;
    chk("reset_result", 32'(bus.result), 32'd0);
    chk("reset_busy",   32'(bus.busy),   32'd0);
    chk("reset_done",   32'(bus.done),   32'd0);
    chk("reset_err",    32'(bus.err),    32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Table-driven vectors (tbl[7] follows an error and must clear err).
    for (int i = 0; i < 8; i++) begin
      x.res = tbl[i].res; x.err = tbl[i].err; x.lat = tbl[i].err ? 2 : 274;
      run_txn($sformatf("vec%0d", i), tbl[i].m, tbl[i].e, tbl[i].n, x, got);
    end

    // Error flag and zero result are held after an error completion.
    run_txn("err_hold", 16'd7, 16'd3, 16'd0, model(16'd7, 16'd3, 16'd0), got);
    repeat (5) tick();
    chk("err_held", 32'(bus.err), 32'd1);
    chk("err_result_held", 32'(bus.result), 32'd0);
    run_txn("err_clear", 16'd2, 16'd10, 16'd1000, model(16'd2, 16'd10, 16'd1000), got);

    // Keygen round trip: p=61, q=53, e=17.
    pk = 61; qk = 53;
    d = mod_inv(17, (pk - 1) * (qk - 1));
    chk("keygen_d", 32'(d), 32'd2753);
    n = 16'(pk * qk);
    run_txn("rt_enc", 16'd1234, 16'd17, n, model(16'd1234, 16'd17, n), ct);
    x.res = 16'd1234; x.err = 1'b0; x.lat = 274;
    run_txn("rt_dec", ct, 16'(d), n, x, got);

    // Random valid vectors against the model.
    for (int i = 0; i < 4; i++) begin
      n = 16'($urandom_range(65535, 2));
      m = 16'($urandom_range(int'(n) - 1, 0));
      ct = 16'($urandom);
      run_txn($sformatf("rnd%0d", i), m, ct, n, model(m, ct, n), got);
    end

    // Start while busy at cycle 100 is ignored.
    sb.push_back(model(16'd65, 16'd17, 16'd3233));
    launch(16'd65, 16'd17, 16'd3233);
    while (cur_cyc < 100) tick();
    bus.start = 1'b1; bus.msg = 16'd2; bus.exponent = 16'd5; bus.modulus = 16'd11;
    tick();
    bus.start = 1'b0;
    finish_txn("busy_start", got);
    dones = 0;
    repeat (20) begin tick(); if (bus.done) dones++; end
    chk("busy_start_no_extra_done", 32'(dones), 32'd0);

    // Asynchronous reset at cycle 150 aborts with no done pulse.
    launch(16'd65, 16'd17, 16'd3233);
    while (cur_cyc < 150) tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_result", 32'(bus.result), 32'd0);
    chk("mid_rst_busy",   32'(bus.busy),   32'd0);
    chk("mid_rst_done",   32'(bus.done),   32'd0);
    chk("mid_rst_err",    32'(bus.err),    32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    dones = 0;
    repeat (300) begin tick(); if (bus.done || bus.busy) dones++; end
    chk("mid_rst_no_activity", 32'(dones), 32'd0);
    run_txn("post_rst", 16'd65, 16'd17, 16'd3233, model(16'd65, 16'd17, 16'd3233), got);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
